// File: rtl/chan_mux_scanner.sv
// chan_mux_scanner: registered CHANNELS:1 multiplexer for WIDTH-bit buses with
// a valid/ready output handshake and lossless back-pressure.
// Optional auto-scan mode (sweeps every channel, DWELL cycles each) is built
// only when the macro MUX_SCAN_EN is defined; otherwise the block is direct-only.
module chan_mux_scanner #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid
);

    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               vld_q, vld_d;

    logic               free;
    logic               cap;
    logic [SEL_W-1:0]   cap_ch;
    logic [WIDTH-1:0]   cap_data;

`ifdef MUX_SCAN_EN
    localparam int CNT_W = $clog2(DWELL) + 1;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
    localparam int unused_dwell = DWELL;
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // The output register may take a new sample when it is empty or being drained.
    assign free = !vld_q || out_ready;

    // Next-state logic: decide whether to capture, and which channel.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        cap_ch  = sel;
`ifdef MUX_SCAN_EN
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_DIRECT: begin
                if (mode) begin
                    // Entry edge never captures; the sweep restarts at channel 0.
                    state_d = S_SCAN;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else if (free) begin
                    cap = 1'b1;
                end
            end
            S_SCAN: begin
                if (!mode) begin
                    state_d = S_DIRECT;
                end else if (cnt_q != CNT_W'(DWELL - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (free) begin
                    cap    = 1'b1;
                    cap_ch = ptr_q;
                    ptr_d  = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
                    cnt_d  = '0;
                end
                // Dwell expired but consumer stalled: hold ptr/cnt so no channel is lost.
            end
            default: state_d = S_DIRECT;
        endcase
`else
        state_d = S_DIRECT;
        cap     = free;
`endif
    end

    // Channel select tree; indices beyond the last channel read as zero.
    always_comb begin
        cap_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cap_ch == SEL_W'(i)) begin
                cap_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register next values: load on capture, drop valid on acceptance.
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        if (cap) begin
            data_d = cap_data;
            ch_d   = cap_ch;
            vld_d  = 1'b1;
        end else if (vld_q && out_ready) begin
            vld_d  = 1'b0;
        end
    end

    // State and output registers; reset discards any pending sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DIRECT;
            data_q  <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
`ifdef MUX_SCAN_EN
            ptr_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
`ifdef MUX_SCAN_EN
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = vld_q;

endmodule
